tcp_tx_packetizer: RTL and testbench
====================================

Name: tcp_tx_packetizer

Overview:
- Multi-channel successor to the single-source TCP TX loopback path.
- Merges NCH byte-stream sources into the single SiTCP TCP TX byte interface (TCP_TX_WR / TCP_TX_DATA / TCP_TX_FULL).
- Wraps each burst in a header/trailer frame carrying channel ID, byte count and end flag.
- Sits between the user data generators and SiTCP in the CLK_200M domain; arbitrates round-robin.

Parameters:
- NCH, 4, number of input channels (1..16).
- MAX_LEN, 256, maximum payload bytes per frame before forced cut (1..32767).
- SYNC_BYTE, 8'hA5, first header byte.

Ports:
- CLK  in  1  system clock (200 MHz).
- SYS_RSTn  in  1  synchronous active-low reset.
- TCP_OPEN_ACK  in  1  SiTCP connection open; low forces the block idle.
- CH_EN  in  NCH  per-channel arbitration enable.
- CH_DATA  in  NCH*8  channel bytes; channel i uses bits [8i+7:8i].
- CH_VALID  in  NCH  channel byte valid.
- CH_LAST  in  NCH  marks the last byte of a burst; qualified by VALID.
- CH_READY  out  NCH  byte accepted when VALID&READY.
- TCP_TX_FULL  in  1  SiTCP almost-full.
- TCP_TX_WR  out  1  SiTCP write enable.
- TCP_TX_DATA  out  8  SiTCP write data.
- FRAME_CNT  out  16  completed frames, wraps at 16'hFFFF->0.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (SYS_RSTn=0 at a CLK edge):
  - state=IDLE; rr pointer=0.
  - TCP_TX_WR=0, TCP_TX_DATA=0, CH_READY=0, FRAME_CNT=0, BUSY=0.
- Frame format: SYNC_BYTE, {4'h5, ch[3:0]}, payload (1..MAX_LEN bytes), {end_flag, cnt[14:8]}, cnt[7:0].
  - cnt = payload byte count.
  - end_flag=1 if the frame ended on CH_LAST, 0 if cut at MAX_LEN.
- All outputs are registered. TCP_TX_WR is high for exactly one cycle per byte. Bytes appear at the output 1 cycle after issue.
- Issue rule: a byte (header, payload or trailer) is issued only in a cycle where TCP_TX_FULL=0 and TCP_OPEN_ACK=1. Otherwise the state holds and TCP_TX_WR=0 next cycle.
- States:
  - IDLE: requesting set = CH_EN & CH_VALID.
    - If non-empty and TCP_OPEN_ACK=1, grant the first requester at or after the rr pointer (wrapping), latch it in gnt, then go to HDR0.
    - rr pointer = gnt+1 mod NCH, updated at grant.
  - HDR0: issue SYNC_BYTE, then go to HDR1.
  - HDR1: issue the ID byte, clear cnt, then go to PAY.
  - PAY: CH_READY[gnt] = (TCP_TX_FULL==0 && TCP_OPEN_ACK==1); all other READY bits are 0. CH_READY is combinational from state/gnt/FULL/OPEN_ACK.
    - On handshake: issue CH_DATA[gnt] and cnt<=cnt+1.
    - If CH_LAST[gnt] was high on that byte: end_flag<=1, go to TRL0.
    - Else if cnt+1==MAX_LEN: end_flag<=0, go to TRL0.
    - No handshake (VALID low): wait indefinitely; no timeout.
  - TRL0: issue {end_flag, cnt[14:8]}, then go to TRL1.
  - TRL1: issue cnt[7:0], FRAME_CNT<=FRAME_CNT+1, then go to IDLE.
- The granted channel keeps ownership until its trailer is sent; no preemption.
- After a MAX_LEN cut, the channel's remaining bytes go in later frames, subject to round robin.
- CH_EN deasserted mid-frame has no effect until IDLE.
- TCP_OPEN_ACK falling mid-frame:
  - Next cycle: state=IDLE, CH_READY=0, TCP_TX_WR=0. The partial frame is abandoned.
  - FRAME_CNT is not incremented. Unaccepted source bytes stay at the source.
- NCH=1: the grant is always channel 0.
- A header/trailer byte is not issued in the same cycle as a payload byte; maximum throughput is 1 byte/cycle.

Test Plan:
- Single frame: ch0 sends 3 bytes 11,22,33 with LAST on 33, FULL=0 -> TX stream A5,50,11,22,33,80,03; FRAME_CNT=1; BUSY low after the final byte.
- Length cut: MAX_LEN=4; ch2 sends 6 bytes with LAST on the 6th.
  - Frame 1: A5,52, 4 payload, 00,04.
  - Frame 2: A5,52, 2 payload, 80,02.
- Round robin: ch0, ch1, ch3 all valid, 1-byte bursts, repeated -> frame ID order 50,51,53,50,51,53; ch2 (CH_EN=0) is never granted.
- Backpressure: toggle TCP_TX_FULL high for 5 cycles mid-payload -> no TCP_TX_WR during those cycles; CH_READY=0; byte order intact; trailer count correct.
- Abort: drop TCP_OPEN_ACK after 2 payload bytes -> IDLE next cycle, no trailer, FRAME_CNT unchanged; after reopen, a new frame starts with A5.
- Reset mid-frame: SYS_RSTn=0 during PAY -> all outputs 0 and FRAME_CNT=0 after the edge; rr pointer=0, so the next grant is the lowest valid channel.

Source files
------------

// File: rtl/tcp_tx_packetizer_if.sv
// Channel source bus and SiTCP TX byte bus for tcp_tx_packetizer.
// The slave modport is the packetizer; master is the source/SiTCP side.
interface tcp_tx_packetizer_if #(
    parameter int NCH = 4
) ();
    logic             TCP_OPEN_ACK;
    logic [NCH-1:0]   CH_EN;
    logic [NCH*8-1:0] CH_DATA;
    logic [NCH-1:0]   CH_VALID;
    logic [NCH-1:0]   CH_LAST;
    logic [NCH-1:0]   CH_READY;
    logic             TCP_TX_FULL;
    logic             TCP_TX_WR;
    logic [7:0]       TCP_TX_DATA;

    modport master (
        output TCP_OPEN_ACK, CH_EN, CH_DATA, CH_VALID, CH_LAST, TCP_TX_FULL,
        input  CH_READY, TCP_TX_WR, TCP_TX_DATA
    );

    modport slave (
        input  TCP_OPEN_ACK, CH_EN, CH_DATA, CH_VALID, CH_LAST, TCP_TX_FULL,
        output CH_READY, TCP_TX_WR, TCP_TX_DATA
    );
endinterface

// File: rtl/tcp_tx_packetizer.sv
// Round-robin merge of NCH byte streams into the SiTCP TX byte interface,
// framing each burst as SYNC, ID, payload, {end_flag, cnt_hi}, cnt_lo.
module tcp_tx_packetizer #(
    parameter int          NCH       = 4,
    parameter int          MAX_LEN   = 256,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                 CLK,
    input  logic                 SYS_RSTn,
    tcp_tx_packetizer_if.slave   bus,
    output logic [15:0]          FRAME_CNT,
    output logic                 BUSY
);
    localparam int              GW        = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [14:0]     MAX_LEN_C = 15'(MAX_LEN);
    localparam logic [GW-1:0]   LAST_CH   = GW'(NCH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_PAY  = 3'd3,
        S_TRL0 = 3'd4,
        S_TRL1 = 3'd5
    } state_e;

    state_e         state_q, state_d;
    logic [GW-1:0]  gnt_q, gnt_d;
    logic [GW-1:0]  rr_q, rr_d;
    logic [14:0]    cnt_q, cnt_d;
    logic           end_flag_q, end_flag_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic           tx_wr_q, tx_wr_d;
    logic [7:0]     tx_data_q, tx_data_d;

    logic           can_issue_s;
    logic [NCH-1:0] req_s;
    logic           req_any_s;
    logic [GW-1:0]  pick_s;
    logic [GW-1:0]  rr_idx_s;
    logic           pay_fire_s;
    logic           pay_last_s;
    logic [7:0]     pay_byte_s;
    logic [14:0]    cnt_inc_s;
    logic [NCH-1:0] ready_s;
    logic           busy_s;

    assign can_issue_s = ~bus.TCP_TX_FULL & bus.TCP_OPEN_ACK;
    assign pay_byte_s  = bus.CH_DATA[{gnt_q, 3'b000} +: 8];
    assign pay_last_s  = bus.CH_LAST[gnt_q];
    assign pay_fire_s  = (state_q == S_PAY) & can_issue_s & bus.CH_VALID[gnt_q];
    assign cnt_inc_s   = cnt_q + 15'd1;

    // Round-robin pick: first requester at or after rr_q; the descending scan
    // lets the nearest requester overwrite farther ones.
    always_comb begin
        req_s     = bus.CH_EN & bus.CH_VALID;
        req_any_s = 1'b0;
        pick_s    = {GW{1'b0}};
        rr_idx_s  = {GW{1'b0}};
        for (int k = NCH - 1; k >= 0; k--) begin
            rr_idx_s = GW'((int'(rr_q) + k) % NCH);
            if (req_s[rr_idx_s]) begin
                req_any_s = 1'b1;
                pick_s    = rr_idx_s;
            end else begin
                req_any_s = req_any_s;
            end
        end
    end

    // State register and registered datapath/outputs.
    always_ff @(posedge CLK) begin
        if (!SYS_RSTn) begin
            state_q     <= S_IDLE;
            gnt_q       <= {GW{1'b0}};
            rr_q        <= {GW{1'b0}};
            cnt_q       <= 15'd0;
            end_flag_q  <= 1'b0;
            frame_cnt_q <= 16'd0;
            tx_wr_q     <= 1'b0;
            tx_data_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            end_flag_q  <= end_flag_d;
            frame_cnt_q <= frame_cnt_d;
            tx_wr_q     <= tx_wr_d;
            tx_data_q   <= tx_data_d;
        end
    end

    // Next-state and byte-issue logic; losing OPEN_ACK abandons the frame.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        end_flag_d  = end_flag_q;
        frame_cnt_d = frame_cnt_q;
        tx_wr_d     = 1'b0;
        tx_data_d   = tx_data_q;
        if (!bus.TCP_OPEN_ACK) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_any_s) begin
                        gnt_d   = pick_s;
                        rr_d    = (pick_s == LAST_CH) ? {GW{1'b0}} : (pick_s + GW'(1'b1));
                        state_d = S_HDR0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HDR0: begin
                    if (can_issue_s) begin
                        tx_wr_d   = 1'b1;
                        tx_data_d = SYNC_BYTE;
                        state_d   = S_HDR1;
                    end else begin
                        state_d = S_HDR0;
                    end
                end
                S_HDR1: begin
                    if (can_issue_s) begin
                        tx_wr_d   = 1'b1;
                        tx_data_d = {4'h5, 4'(gnt_q)};
                        cnt_d     = 15'd0;
                        state_d   = S_PAY;
                    end else begin
                        state_d = S_HDR1;
                    end
                end
                S_PAY: begin
                    if (pay_fire_s) begin
                        tx_wr_d   = 1'b1;
                        tx_data_d = pay_byte_s;
                        cnt_d     = cnt_inc_s;
                        if (pay_last_s) begin
                            end_flag_d = 1'b1;
                            state_d    = S_TRL0;
                        end else if (cnt_inc_s == MAX_LEN_C) begin
                            end_flag_d = 1'b0;
                            state_d    = S_TRL0;
                        end else begin
                            state_d = S_PAY;
                        end
                    end else begin
                        state_d = S_PAY;
                    end
                end
                S_TRL0: begin
                    if (can_issue_s) begin
                        tx_wr_d   = 1'b1;
                        tx_data_d = {end_flag_q, cnt_q[14:8]};
                        state_d   = S_TRL1;
                    end else begin
                        state_d = S_TRL0;
                    end
                end
                S_TRL1: begin
                    if (can_issue_s) begin
                        tx_wr_d     = 1'b1;
                        tx_data_d   = cnt_q[7:0];
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_TRL1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode: READY follows the owner's issue slot directly.
    always_comb begin
        ready_s = {NCH{1'b0}};
        busy_s  = (state_q != S_IDLE);
        if ((state_q == S_PAY) && can_issue_s) begin
            ready_s[gnt_q] = 1'b1;
        end else begin
            ready_s = {NCH{1'b0}};
        end
    end

    assign bus.CH_READY    = ready_s;
    assign bus.TCP_TX_WR   = tx_wr_q;
    assign bus.TCP_TX_DATA = tx_data_q;
    assign FRAME_CNT       = frame_cnt_q;
    assign BUSY            = busy_s;
endmodule

// File: tb/tb_tcp_tx_packetizer.sv
// Bench for tcp_tx_packetizer: queued channel sources, a frame-level
// reference model of arbitration/framing, and per-scenario checks.
module tb_tcp_tx_packetizer;
    localparam int NCH     = 4;
    localparam int MAX_LEN = 4;
    localparam int DEPTH   = 1024;

    logic        CLK;
    logic        SYS_RSTn;
    logic [15:0] FRAME_CNT;
    logic        BUSY;

    tcp_tx_packetizer_if #(.NCH(NCH)) bus ();

    tcp_tx_packetizer #(.NCH(NCH), .MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5)) dut (
        .CLK(CLK), .SYS_RSTn(SYS_RSTn), .bus(bus), .FRAME_CNT(FRAME_CNT), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [8:0] src_mem [NCH][DEPTH];
    int         src_head [NCH];
    int         src_tail [NCH];
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int         rr_m, fc_m, exp_frames;
    int         checks, failures;
    logic       open_v;
    bit         rand_full;
    int         cyc, win_lo, win_hi;
    int         wr_full_viol, rdy_full_viol;

    task automatic drive_src();
        for (int c = 0; c < NCH; c++) begin
            if (src_head[c] < src_tail[c]) begin
                bus.CH_VALID[c]       = 1'b1;
                bus.CH_DATA[c*8 +: 8] = src_mem[c][src_head[c]][7:0];
                bus.CH_LAST[c]        = src_mem[c][src_head[c]][8];
            end else begin
                bus.CH_VALID[c]       = 1'b0;
                bus.CH_DATA[c*8 +: 8] = 8'h00;
                bus.CH_LAST[c]        = 1'b0;
            end
        end
    endtask

    task automatic push_byte(input int c, input logic [7:0] d, input logic last);
        src_mem[c][src_tail[c]] = {last, d};
        src_tail[c]++;
    endtask

    task automatic push_burst(input int c, input int len);
        for (int i = 0; i < len; i++) push_byte(c, 8'($urandom_range(0, 255)), (i == len - 1));
    endtask

    // One clock: sample handshakes mid-cycle, then collect output and redrive after the edge.
    task automatic cycle();
        logic [NCH-1:0] fire;
        logic           full_e;
        @(negedge CLK);
        fire   = bus.CH_VALID & bus.CH_READY & {NCH{SYS_RSTn}};
        full_e = bus.TCP_TX_FULL;
        if (bus.TCP_TX_FULL && (bus.CH_READY != 4'b0000)) rdy_full_viol++;
        @(posedge CLK);
        #1;
        for (int c = 0; c < NCH; c++) if (fire[c]) src_head[c]++;
        if (bus.TCP_TX_WR) begin
            got_q.push_back(bus.TCP_TX_DATA);
            if (full_e) wr_full_viol++;
        end
        cyc++;
        bus.TCP_TX_FULL  = ((cyc >= win_lo) && (cyc <= win_hi)) || (rand_full && ($urandom_range(0, 9) < 3));
        bus.TCP_OPEN_ACK = open_v;
        drive_src();
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        int k = 0;
        while ((got_q.size() < n) && (k < budget)) begin
            cycle();
            k++;
        end
        ok = (got_q.size() >= n);
    endtask

    // Frame-level reference: whole frames from the queued source contents.
    task automatic build_expected();
        int         h [NCH];
        int         ch, n;
        logic       endf;
        logic [8:0] e;
        bit         more;
        exp_q.delete();
        exp_frames = 0;
        for (int c = 0; c < NCH; c++) h[c] = src_head[c];
        more = 1'b1;
        while (more) begin
            ch = -1;
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (rr_m + k) % NCH;
                if ((ch < 0) && bus.CH_EN[c] && (h[c] < src_tail[c])) ch = c;
            end
            if (ch < 0) begin
                more = 1'b0;
            end else begin
                rr_m = (ch + 1) % NCH;
                exp_q.push_back(8'hA5);
                exp_q.push_back(8'h50 | 8'(ch));
                n    = 0;
                endf = 1'b0;
                while ((n < MAX_LEN) && !endf && (h[ch] < src_tail[ch])) begin
                    e = src_mem[ch][h[ch]];
                    h[ch]++;
                    exp_q.push_back(e[7:0]);
                    n++;
                    endf = e[8];
                end
                exp_q.push_back({endf, 7'(n >> 8)});
                exp_q.push_back(8'(n & 255));
                exp_frames++;
            end
        end
    endtask

    task automatic test_reset();
        SYS_RSTn = 1'b0;
        cycle();
        cycle();
        checks += 5;
        if (bus.TCP_TX_WR !== 1'b0) begin failures++; $display("FAIL reset_wr: got %b want 0", bus.TCP_TX_WR); end
        if (bus.TCP_TX_DATA !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", bus.TCP_TX_DATA); end
        if (bus.CH_READY !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b want 0000", bus.CH_READY); end
        if (FRAME_CNT !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt: got %0d want 0", FRAME_CNT); end
        if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        SYS_RSTn = 1'b1;
        rr_m = 0;
        fc_m = 0;
        got_q.delete();
    endtask

    task automatic test_single_frame();
        logic [7:0] ref_b [7];
        bit ok;
        ref_b = '{8'hA5, 8'h50, 8'h11, 8'h22, 8'h33, 8'h80, 8'h03};
        got_q.delete();
        bus.CH_EN = 4'b0001;
        push_byte(0, 8'h11, 1'b0);
        push_byte(0, 8'h22, 1'b0);
        push_byte(0, 8'h33, 1'b1);
        drive_src();
        build_expected();
        wait_bytes(7, 200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_timeout: got %0d bytes want 7", got_q.size()); end
        for (int i = 0; i < 7 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== ref_b[i]) begin failures++; $display("FAIL single_byte%0d: got %h want %h", i, got_q[i], ref_b[i]); end
        end
        fc_m += exp_frames;
        checks += 2;
        if (FRAME_CNT !== 16'd1) begin failures++; $display("FAIL single_frame_cnt: got %0d want 1", FRAME_CNT); end
        if (BUSY !== 1'b0) begin failures++; $display("FAIL single_busy: got %b want 0", BUSY); end
    endtask

    task automatic test_length_cut();
        bit ok;
        got_q.delete();
        bus.CH_EN = 4'b0100;
        push_burst(2, 6);
        drive_src();
        build_expected();
        wait_bytes(exp_q.size(), 300, ok);
        checks += 2;
        if (!ok) begin failures++; $display("FAIL cut_timeout: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        if (got_q.size() != 14) begin failures++; $display("FAIL cut_len: got %0d bytes want 14", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL cut_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() >= 14) begin
            checks += 4;
            if (got_q[6] !== 8'h00) begin failures++; $display("FAIL cut_flag1: got %h want 00", got_q[6]); end
            if (got_q[7] !== 8'h04) begin failures++; $display("FAIL cut_cnt1: got %h want 04", got_q[7]); end
            if (got_q[12] !== 8'h80) begin failures++; $display("FAIL cut_flag2: got %h want 80", got_q[12]); end
            if (got_q[13] !== 8'h02) begin failures++; $display("FAIL cut_cnt2: got %h want 02", got_q[13]); end
        end
        fc_m += exp_frames;
        checks++;
        if (FRAME_CNT !== 16'(fc_m)) begin failures++; $display("FAIL cut_frame_cnt: got %0d want %0d", FRAME_CNT, fc_m); end
    endtask

    task automatic test_round_robin();
        logic [7:0] ids [6];
        int h2;
        bit ok;
        ids = '{8'h50, 8'h51, 8'h53, 8'h50, 8'h51, 8'h53};
        SYS_RSTn = 1'b0;
        cycle();
        SYS_RSTn = 1'b1;
        rr_m = 0;
        fc_m = 0;
        got_q.delete();
        bus.CH_EN = 4'b1011;
        for (int r = 0; r < 2; r++) begin
            push_burst(0, 1);
            push_burst(1, 1);
            push_burst(3, 1);
        end
        push_burst(2, 3);
        h2 = src_head[2];
        drive_src();
        build_expected();
        wait_bytes(exp_q.size(), 400, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rr_timeout: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rr_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        for (int f = 0; f < 6 && (5 * f + 1) < got_q.size(); f++) begin
            checks++;
            if (got_q[5*f+1] !== ids[f]) begin failures++; $display("FAIL rr_id%0d: got %h want %h", f, got_q[5*f+1], ids[f]); end
        end
        checks++;
        if (src_head[2] !== h2) begin failures++; $display("FAIL rr_ch2_untouched: got head %0d want %0d", src_head[2], h2); end
        src_head[2] = src_tail[2];
        drive_src();
        fc_m += exp_frames;
    endtask

    task automatic test_backpressure();
        bit ok;
        got_q.delete();
        wr_full_viol  = 0;
        rdy_full_viol = 0;
        bus.CH_EN = 4'b0010;
        push_burst(1, 3);
        drive_src();
        build_expected();
        cyc    = 0;
        win_lo = 4;
        win_hi = 8;
        repeat (9) cycle();
        checks++;
        if (got_q.size() != 3) begin failures++; $display("FAIL bp_stalled: got %0d bytes want 3", got_q.size()); end
        wait_bytes(exp_q.size(), 200, ok);
        win_lo = -1;
        win_hi = -2;
        checks += 3;
        if (!ok) begin failures++; $display("FAIL bp_timeout: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        if (wr_full_viol != 0) begin failures++; $display("FAIL bp_wr_while_full: got %0d want 0", wr_full_viol); end
        if (rdy_full_viol != 0) begin failures++; $display("FAIL bp_ready_while_full: got %0d want 0", rdy_full_viol); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        fc_m += exp_frames;
        checks++;
        if (FRAME_CNT !== 16'(fc_m)) begin failures++; $display("FAIL bp_frame_cnt: got %0d want %0d", FRAME_CNT, fc_m); end
    endtask

    task automatic test_random();
        bit ok;
        rand_full = 1'b1;
        for (int r = 0; r < 8; r++) begin
            got_q.delete();
            wr_full_viol  = 0;
            rdy_full_viol = 0;
            bus.CH_EN = 4'($urandom_range(1, 15));
            for (int c = 0; c < NCH; c++) begin
                int nb;
                nb = $urandom_range(0, 2);
                for (int b = 0; b < nb; b++) push_burst(c, $urandom_range(1, 9));
            end
            drive_src();
            build_expected();
            wait_bytes(exp_q.size(), 3000, ok);
            checks += 3;
            if (!ok) begin failures++; $display("FAIL rand%0d_timeout: got %0d bytes want %0d", r, got_q.size(), exp_q.size()); end
            if (wr_full_viol != 0) begin failures++; $display("FAIL rand%0d_wr_while_full: got %0d want 0", r, wr_full_viol); end
            if (rdy_full_viol != 0) begin failures++; $display("FAIL rand%0d_ready_while_full: got %0d want 0", r, rdy_full_viol); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_byte%0d: got %h want %h", r, i, got_q[i], exp_q[i]); end
            end
            fc_m += exp_frames;
            checks += 2;
            if (FRAME_CNT !== 16'(fc_m)) begin failures++; $display("FAIL rand%0d_frame_cnt: got %0d want %0d", r, FRAME_CNT, fc_m); end
            if (BUSY !== 1'b0) begin failures++; $display("FAIL rand%0d_busy: got %b want 0", r, BUSY); end
        end
        rand_full = 1'b0;
        bus.TCP_TX_FULL = 1'b0;
        for (int c = 0; c < NCH; c++) src_head[c] = src_tail[c];
        drive_src();
        cycle();
    endtask

    task automatic test_abort();
        bit ok;
        got_q.delete();
        bus.CH_EN = 4'b0001;
        push_burst(0, 3);
        drive_src();
        wait_bytes(4, 200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL abort_start_timeout: got %0d bytes want 4", got_q.size()); end
        open_v = 1'b0;
        bus.TCP_OPEN_ACK = 1'b0;
        cycle();
        checks += 5;
        if (BUSY !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", BUSY); end
        if (bus.TCP_TX_WR !== 1'b0) begin failures++; $display("FAIL abort_wr: got %b want 0", bus.TCP_TX_WR); end
        if (bus.CH_READY !== 4'b0000) begin failures++; $display("FAIL abort_ready: got %b want 0000", bus.CH_READY); end
        if (FRAME_CNT !== 16'(fc_m)) begin failures++; $display("FAIL abort_frame_cnt: got %0d want %0d", FRAME_CNT, fc_m); end
        if ((src_tail[0] - src_head[0]) != 1) begin failures++; $display("FAIL abort_src_left: got %0d want 1", src_tail[0] - src_head[0]); end
        repeat (4) cycle();
        checks++;
        if (got_q.size() != 4) begin failures++; $display("FAIL abort_no_trailer: got %0d bytes want 4", got_q.size()); end
        open_v = 1'b1;
        bus.TCP_OPEN_ACK = 1'b1;
        got_q.delete();
        rr_m = 1;  // ch0 was granted for the abandoned frame
        build_expected();
        wait_bytes(exp_q.size(), 200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL abort_reopen_timeout: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL abort_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        fc_m += exp_frames;
        checks++;
        if (FRAME_CNT !== 16'(fc_m)) begin failures++; $display("FAIL abort_reopen_frame_cnt: got %0d want %0d", FRAME_CNT, fc_m); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        got_q.delete();
        bus.CH_EN = 4'b1010;
        push_burst(1, 3);
        push_burst(3, 3);
        drive_src();
        wait_bytes(3, 200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rstmid_start_timeout: got %0d bytes want 3", got_q.size()); end
        SYS_RSTn = 1'b0;
        cycle();
        checks += 5;
        if (bus.TCP_TX_WR !== 1'b0) begin failures++; $display("FAIL rstmid_wr: got %b want 0", bus.TCP_TX_WR); end
        if (bus.TCP_TX_DATA !== 8'h00) begin failures++; $display("FAIL rstmid_data: got %h want 00", bus.TCP_TX_DATA); end
        if (bus.CH_READY !== 4'b0000) begin failures++; $display("FAIL rstmid_ready: got %b want 0000", bus.CH_READY); end
        if (FRAME_CNT !== 16'd0) begin failures++; $display("FAIL rstmid_frame_cnt: got %0d want 0", FRAME_CNT); end
        if (BUSY !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", BUSY); end
        SYS_RSTn = 1'b1;
        rr_m = 0;
        fc_m = 0;
        got_q.delete();
        build_expected();
        wait_bytes(exp_q.size(), 300, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rstmid_timeout: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() > 1) begin
            checks++;
            if (got_q[1] !== 8'h51) begin failures++; $display("FAIL rstmid_first_id: got %h want 51", got_q[1]); end
        end
        fc_m += exp_frames;
        checks++;
        if (FRAME_CNT !== 16'(fc_m)) begin failures++; $display("FAIL rstmid_frame_cnt_after: got %0d want %0d", FRAME_CNT, fc_m); end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        cyc              = 0;
        win_lo           = -1;
        win_hi           = -2;
        rand_full        = 1'b0;
        open_v           = 1'b1;
        wr_full_viol     = 0;
        rdy_full_viol    = 0;
        rr_m             = 0;
        fc_m             = 0;
        SYS_RSTn         = 1'b0;
        bus.TCP_OPEN_ACK = 1'b1;
        bus.TCP_TX_FULL  = 1'b0;
        bus.CH_EN        = 4'b0000;
        for (int c = 0; c < NCH; c++) begin
            src_head[c] = 0;
            src_tail[c] = 0;
        end
        drive_src();
        test_reset();
        test_single_frame();
        test_length_cut();
        test_round_robin();
        test_backpressure();
        test_random();
        test_abort();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end
endmodule
